// File: rtl/edge_detect_array.sv
// -----------------------------------------------------------------------------
// edge_detect_array
//
// Multi-channel edge detector for asynchronous board pins (UART RX, buttons,
// start strobes). Each channel runs an N-stage synchroniser, a
// consecutive-sample debounce filter and registered single-cycle edge pulses.
// The edge mode is chosen at run time and shared by all channels.
//
// Optional feature: define EDGE_DET_STICKY_EN to add per-channel sticky edge
// flags (sticky_flag) with a per-channel clear (flag_clr). Without the macro
// those ports and their flops do not exist; everything else is identical.
//
// Parameters
//   CH           number of independent input channels
//   SYNC_STAGES  synchroniser flops per channel (>= 2)
//   DEB_CYCLES   consecutive disagreeing samples needed to accept a new level (>= 1)
//   IDLE_LEVEL   reset/idle level of every channel
//
// Ports
//   clock        system clock, all logic on posedge
//   reset_n      synchronous active-low reset
//   pin_in       asynchronous raw inputs, one bit per channel
//   edge_mode    00 off, 01 rising, 10 falling, 11 both
//   level_out    debounced, synchronised level
//   sig_L2H      1-cycle pulse on an accepted low->high transition
//   sig_H2L      1-cycle pulse on an accepted high->low transition
//   sig_edge     sig_L2H | sig_H2L
//   sticky_flag  latched sig_edge               (EDGE_DET_STICKY_EN only)
//   flag_clr     per-channel sticky_flag clear  (EDGE_DET_STICKY_EN only)
// -----------------------------------------------------------------------------
module edge_detect_array #(
    parameter int CH          = 8,
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CYCLES  = 16,
    parameter bit IDLE_LEVEL  = 1'b1
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic [CH-1:0] pin_in,
    input  logic [1:0]    edge_mode,
    output logic [CH-1:0] level_out,
    output logic [CH-1:0] sig_L2H,
    output logic [CH-1:0] sig_H2L,
`ifdef EDGE_DET_STICKY_EN
    output logic [CH-1:0] sticky_flag,
    input  logic [CH-1:0] flag_clr,
`endif
    output logic [CH-1:0] sig_edge
);

    localparam int            CW       = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);
    localparam logic [CH-1:0] IDLE_VEC = {CH{IDLE_LEVEL}};

    logic [CH-1:0] sync_ff [SYNC_STAGES];
    logic [CH-1:0] sync_q;
    logic [CW-1:0] deb_cnt      [CH];
    logic [CW-1:0] deb_cnt_next [CH];
    logic [CH-1:0] level_next;
    logic [CH-1:0] accept;
    logic [CH-1:0] l2h_next;
    logic [CH-1:0] h2l_next;
    logic [CH-1:0] edge_next;

    // Synchroniser chain. Stage 0 is the only flop that sees pin_in.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_ff[s] <= IDLE_VEC;
            end
        end else begin
            sync_ff[0] <= pin_in;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_ff[s] <= sync_ff[s-1];
            end
        end
    end

    assign sync_q = sync_ff[SYNC_STAGES-1];

    // Debounce: the counter holds the number of disagreeing samples already
    // seen, so the DEB_CYCLES-th consecutive disagreeing sample is accepted.
    // A single agreeing sample restarts the count.
    always_comb begin
        accept     = '0;
        level_next = level_out;
        for (int i = 0; i < CH; i++) begin
            deb_cnt_next[i] = deb_cnt[i];
            if (sync_q[i] == level_out[i]) begin
                deb_cnt_next[i] = '0;
            end else if (deb_cnt[i] == CNT_LAST) begin
                accept[i]       = 1'b1;
                level_next[i]   = sync_q[i];
                deb_cnt_next[i] = '0;
            end else begin
                deb_cnt_next[i] = deb_cnt[i] + CW'(1);
            end
        end
    end

    // edge_mode only matters on the accept edge.
    always_comb begin
        l2h_next  = accept &  sync_q & {CH{edge_mode[0]}};
        h2l_next  = accept & ~sync_q & {CH{edge_mode[1]}};
        edge_next = l2h_next | h2l_next;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            level_out <= IDLE_VEC;
            sig_L2H   <= '0;
            sig_H2L   <= '0;
            sig_edge  <= '0;
            for (int i = 0; i < CH; i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            level_out <= level_next;
            sig_L2H   <= l2h_next;
            sig_H2L   <= h2l_next;
            sig_edge  <= edge_next;
            for (int i = 0; i < CH; i++) begin
                deb_cnt[i] <= deb_cnt_next[i];
            end
        end
    end

`ifdef EDGE_DET_STICKY_EN
    // A new edge wins over a clear in the same cycle.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            sticky_flag <= '0;
        end else begin
            sticky_flag <= (sticky_flag & ~flag_clr) | edge_next;
        end
    end
`endif

endmodule

// File: tb/tb_edge_detect_array.sv
// -----------------------------------------------------------------------------
// tb_edge_detect_array
//
// Directed bench for edge_detect_array with default parameters
// (CH=8, SYNC_STAGES=2, DEB_CYCLES=16, IDLE_LEVEL=1). A pin change driven just
// after an edge is first sampled on the next edge (index 1); the accepted
// pulse is then visible after edge index 18 (17 edges after the sampling edge).
// -----------------------------------------------------------------------------
module tb_edge_detect_array;

    logic       clock = 1'b0;
    logic       reset_n;
    logic [7:0] pin_in;
    logic [1:0] edge_mode;
    logic [7:0] level_out;
    logic [7:0] sig_L2H;
    logic [7:0] sig_H2L;
    logic [7:0] sig_edge;
`ifdef EDGE_DET_STICKY_EN
    logic [7:0] sticky_flag;
    logic [7:0] flag_clr;
`endif

    int total = 0;
    int bad   = 0;

    edge_detect_array dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .pin_in      (pin_in),
        .edge_mode   (edge_mode),
        .level_out   (level_out),
        .sig_L2H     (sig_L2H),
        .sig_H2L     (sig_H2L),
`ifdef EDGE_DET_STICKY_EN
        .sticky_flag (sticky_flag),
        .flag_clr    (flag_clr),
`endif
        .sig_edge    (sig_edge)
    );

    // Clock / watchdog
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // Checking
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drivers
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Steps n cycles and records pulse activity: counts on channel ch, cycles
    // with any pulse on any channel, and index of the first pulse on ch.
    task automatic watch(input int n, input int ch,
                         output int n_l2h, output int n_h2l, output int n_edge,
                         output int n_any, output int first);
        n_l2h = 0; n_h2l = 0; n_edge = 0; n_any = 0; first = 0;
        for (int k = 1; k <= n; k++) begin
            @(posedge clock);
            #1;
            if (sig_L2H[ch]) n_l2h++;
            if (sig_H2L[ch]) n_h2l++;
            if (sig_edge[ch]) begin
                n_edge++;
                if (first == 0) first = k;
            end
            if ((sig_edge | sig_L2H | sig_H2L) != 8'h00) n_any++;
        end
    endtask

    initial begin
        int l, h, e, a, f;

        // 1: reset
        reset_n   = 1'b0;
        pin_in    = 8'hFF;
        edge_mode = 2'b11;
`ifdef EDGE_DET_STICKY_EN
        flag_clr  = 8'h00;
`endif
        step(3);
        check("rst_level", level_out, 8'hFF);
        check("rst_l2h",   sig_L2H,   8'h00);
        check("rst_h2l",   sig_H2L,   8'h00);
        check("rst_edge",  sig_edge,  8'h00);
`ifdef EDGE_DET_STICKY_EN
        check("rst_sticky", sticky_flag, 8'h00);
`endif
        reset_n = 1'b1;
        watch(25, 0, l, h, e, a, f);
        check("rel_any",   a, 0);
        check("rel_level", level_out, 8'hFF);

        // 2: falling edge, mode 10
        edge_mode = 2'b10;
        pin_in[0] = 1'b0;
        watch(30, 0, l, h, e, a, f);
        check("fall_h2l",   h, 1);
        check("fall_l2h",   l, 0);
        check("fall_edge",  e, 1);
        check("fall_any",   a, 1);
        check("fall_time",  f, 18);
        check("fall_level", level_out, 8'hFE);
        pin_in[0] = 1'b1;
        watch(30, 0, l, h, e, a, f);
        check("rise_m10_any", a, 0);
        check("rise_m10_lvl", level_out, 8'hFF);

        // 3: glitch of 15 samples is filtered, 16 samples is accepted
        edge_mode = 2'b11;
        pin_in[3] = 1'b0;
        watch(15, 3, l, h, e, a, f);
        check("gl15_any_a", a, 0);
        pin_in[3] = 1'b1;
        watch(30, 3, l, h, e, a, f);
        check("gl15_any_b", a, 0);
        check("gl15_level", level_out, 8'hFF);
        pin_in[3] = 1'b0;
        watch(16, 3, l, h, e, a, f);
        check("gl16_any_a", a, 0);
        pin_in[3] = 1'b1;
        watch(40, 3, l, h, e, a, f);
        check("gl16_h2l",   h, 1);
        check("gl16_time",  f, 2);
        check("gl16_l2h",   l, 1);
        check("gl16_edge",  e, 2);
        check("gl16_level", level_out, 8'hFF);

        // 4: mode 01, 11, 00 on ch1
        edge_mode = 2'b01;
        pin_in[1] = 1'b0;
        watch(40, 1, l, h, e, a, f);
        check("m01_fall_any", a, 0);
        check("m01_fall_lvl", level_out, 8'hFD);
        pin_in[1] = 1'b1;
        watch(40, 1, l, h, e, a, f);
        check("m01_rise_l2h", l, 1);
        check("m01_rise_h2l", h, 0);
        check("m01_rise_lvl", level_out, 8'hFF);

        edge_mode = 2'b11;
        pin_in[1] = 1'b0;
        watch(40, 1, l, h, e, a, f);
        check("m11_fall_h2l", h, 1);
        check("m11_fall_l2h", l, 0);
        pin_in[1] = 1'b1;
        watch(40, 1, l, h, e, a, f);
        check("m11_rise_l2h", l, 1);
        check("m11_rise_h2l", h, 0);

        edge_mode = 2'b00;
        pin_in[1] = 1'b0;
        watch(40, 1, l, h, e, a, f);
        check("m00_fall_any", a, 0);
        check("m00_fall_lvl", level_out, 8'hFD);
        pin_in[1] = 1'b1;
        watch(40, 1, l, h, e, a, f);
        check("m00_rise_any", a, 0);
        check("m00_rise_lvl", level_out, 8'hFF);

        // 5a: all channels fall together
        edge_mode = 2'b10;
        pin_in    = 8'h00;
        step(17);
        check("all_pre",   sig_H2L, 8'h00);
        step(1);
        check("all_h2l",   sig_H2L, 8'hFF);
        check("all_edge",  sig_edge, 8'hFF);
        check("all_level", level_out, 8'h00);
        step(1);
        check("all_post",  sig_H2L, 8'h00);
        pin_in = 8'hFF;
        step(40);
        check("all_back",  level_out, 8'hFF);

        // 5b: reset pulse with ch2 counter at 10
        edge_mode = 2'b11;
        pin_in[2] = 1'b0;
        step(12);
        reset_n = 1'b0;
        step(1);
        check("mid_rst_edge",  sig_edge, 8'h00);
        check("mid_rst_level", level_out, 8'hFF);
        reset_n = 1'b1;
        watch(30, 2, l, h, e, a, f);
        check("mid_rst_h2l",  h, 1);
        check("mid_rst_time", f, 18);
        check("mid_rst_any",  a, 1);
        pin_in[2] = 1'b1;
        step(40);

`ifdef EDGE_DET_STICKY_EN
        // 6: sticky flags
        flag_clr = 8'hFF;
        step(1);
        flag_clr = 8'h00;
        check("stk_clear_all", sticky_flag, 8'h00);
        pin_in[5] = 1'b0;
        watch(20, 5, l, h, e, a, f);
        check("stk_set", sticky_flag, 8'h20);
        step(10);
        check("stk_hold", sticky_flag, 8'h20);
        flag_clr[5] = 1'b1;
        step(1);
        flag_clr = 8'h00;
        check("stk_clr", sticky_flag, 8'h00);
        flag_clr[5] = 1'b1;
        pin_in[5]   = 1'b1;
        step(17);
        check("stk_pre", sticky_flag, 8'h00);
        step(1);
        flag_clr = 8'h00;
        check("stk_pulse", sig_L2H, 8'h20);
        check("stk_set_wins", sticky_flag, 8'h20);
        step(1);
        check("stk_kept", sticky_flag, 8'h20);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
